// File: rtl/cskip_arbiter.sv
// Two-requester round-robin front end for a shared pipelined carry-skip adder.
// Results are returned in issue order through a credit-bounded result FIFO.
module cskip_arbiter #(
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req1_ready,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    input  logic [16:0] add_sum,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [16:0] rsp_sum,
    input  logic        rsp_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic        id;
        logic [16:0] sum;
    } rsp_t;

    logic [CW-1:0] credit;
    logic          last_id;
    logic          gnt0, gnt1, issue;
    logic [LAT:0]  vld_pipe;
    logic [LAT:0]  id_pipe;

    rsp_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit covers both in-flight adds and queued results, so a capture
    // can never find the FIFO full.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && credit < CW'(DEPTH)) begin
            if (req0_valid && req1_valid) begin
                if (last_id) gnt0 = 1'b1;
                else         gnt1 = 1'b1;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign issue      = gnt0 | gnt1;
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            add_a    <= '0;
            add_b    <= '0;
            last_id  <= 1'b1;
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            if (issue) begin
                add_a   <= gnt1 ? req1_a : req0_a;
                add_b   <= gnt1 ? req1_b : req0_b;
                last_id <= gnt1;
            end
            vld_pipe <= {vld_pipe[LAT-1:0], issue};
            id_pipe  <= {id_pipe[LAT-1:0], gnt1};
        end
    end

    // The last pipe stage lines up with add_sum for the same operands.
    assign push = vld_pipe[LAT];
    assign pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= '0;
        end else begin
            case ({issue, pop})
                2'b10:   credit <= credit + 1'b1;
                2'b01:   credit <= credit - 1'b1;
                default: credit <= credit;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{id: id_pipe[LAT], sum: add_sum};
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rsp_valid = (count != '0);
    assign rsp_id    = mem[rd_ptr].id;
    assign rsp_sum   = mem[rd_ptr].sum;

endmodule

// File: tb/tb_cskip_arbiter.sv
// Directed bench for cskip_arbiter with a LAT-stage behavioural adder model.
module tb_cskip_arbiter;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [15:0] add_a, add_b;
    logic [16:0] add_sum;
    logic        rsp_valid, rsp_id, rsp_ready;
    logic [16:0] rsp_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cskip_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready)
    );

    // external adder: LAT register stages
    logic [16:0] sum_pipe [LAT];
    always @(posedge clk) begin
        sum_pipe[0] <= {1'b0, add_a} + {1'b0, add_b};
        for (int i = 1; i < LAT; i++) sum_pipe[i] <= sum_pipe[i-1];
    end
    assign add_sum = sum_pipe[LAT-1];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        rsp_ready = 0;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        rsp_ready = 0;
        req0_valid = 1; req1_valid = 1;
        req0_a = 16'hAAAA; req0_b = 16'h5555; req1_a = 16'h1111; req1_b = 16'h2222;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready);
        end
        step();
        step();
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_held got=%b%b exp=00", req0_ready, req1_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++;
        if (add_a !== 16'h0 || add_b !== 16'h0) begin
            errors++; $display("FAIL reset_add got=%h/%h exp=0000/0000", add_a, add_b);
        end
        checks++;
        if (rsp_id !== 1'b0 || rsp_sum !== 17'h0) begin
            errors++; $display("FAIL reset_rsp got=%b/%h exp=0/00000", rsp_id, rsp_sum);
        end
        rst = 0;
        idle_inputs();
    endtask

    task automatic test_single_issue();
        do_reset();
        req0_valid = 1; req0_a = 16'h1234; req0_b = 16'h0FF0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL single_grant got=%b%b exp=10", req0_ready, req1_ready);
        end
        step();
        req0_valid = 0;
        checks++;
        if (add_a !== 16'h1234 || add_b !== 16'h0FF0) begin
            errors++; $display("FAIL single_operands got=%h/%h exp=1234/0ff0", add_a, add_b);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_t1 got=%b exp=0", rsp_valid); end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_t2 got=%b exp=0", rsp_valid); end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_sum !== 17'h02224) begin
            errors++; $display("FAIL single_result got=%b/%b/%h exp=1/0/02224", rsp_valid, rsp_id, rsp_sum);
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_pop got=%b exp=0", rsp_valid); end
    endtask

    task automatic test_carry_out();
        do_reset();
        req1_valid = 1; req1_a = 16'hFFFF; req1_b = 16'h0001;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++; $display("FAIL carry_grant got=%b%b exp=01", req0_ready, req1_ready);
        end
        step();
        req1_valid = 0;
        step();
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_sum !== 17'h10000) begin
            errors++; $display("FAIL carry_result got=%b/%b/%h exp=1/1/10000", rsp_valid, rsp_id, rsp_sum);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_sum !== 17'h10000) begin
            errors++; $display("FAIL carry_hold got=%b/%b/%h exp=1/1/10000", rsp_valid, rsp_id, rsp_sum);
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
    endtask

    task automatic test_contention();
        logic [17:0] q[$];
        int nrx;
        do_reset();
        rsp_ready = 1;
        nrx = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 6) begin
                req0_valid = 1; req0_a = 16'h0100 + 16'(c); req0_b = 16'(c);
                req1_valid = 1; req1_a = 16'h2000 + 16'(c); req1_b = 16'h0010;
                #1;
                checks++;
                if (req0_ready !== ~c[0] || req1_ready !== c[0]) begin
                    errors++; $display("FAIL contention_grant c=%0d got=%b%b exp=%b%b",
                                       c, req0_ready, req1_ready, ~c[0], c[0]);
                end
                if (c[0]) q.push_back({1'b1, 17'h2010 + 17'(c)});
                else      q.push_back({1'b0, 17'h0100 + 17'(2 * c)});
            end else begin
                idle_inputs();
            end
            if (rsp_valid) begin
                checks++;
                if (q.size() == 0 || {rsp_id, rsp_sum} !== q[0]) begin
                    errors++; $display("FAIL contention_order n=%0d got=%b/%h", nrx, rsp_id, rsp_sum);
                end
                if (q.size() != 0) void'(q.pop_front());
                nrx++;
            end
            step();
        end
        checks++;
        if (nrx != 6) begin errors++; $display("FAIL contention_count got=%0d exp=6", nrx); end
        rsp_ready = 0;
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        req0_valid = 1; req0_a = 16'h0003; req0_b = 16'h0004;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req0_ready) n++;
            step();
        end
        checks++;
        if (n != DEPTH) begin errors++; $display("FAIL bp_issues got=%0d exp=%0d", n, DEPTH); end
        checks++;
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_blocked got=%b exp=0", req0_ready); end
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_head got=%b exp=1", rsp_valid); end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (req0_ready) n++;
            step();
        end
        checks++;
        if (n != 1) begin errors++; $display("FAIL bp_after_pop got=%0d exp=1", n); end
        idle_inputs();
        rsp_ready = 1;
        for (int c = 0; c < 8; c++) step();
        rsp_ready = 0;
    endtask

    task automatic test_issue_and_pop();
        logic [17:0] q[$];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1; req0_a = 16'h0010 + 16'(i); req0_b = 16'h0001;
            q.push_back({1'b0, 17'h0011 + 17'(i)});
            step();
        end
        idle_inputs();
        for (int c = 0; c < 4; c++) step();
        // credit = DEPTH-1 here: issue and pop together
        req1_valid = 1; req1_a = 16'h0500; req1_b = 16'h0005;
        rsp_ready = 1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin errors++; $display("FAIL ip_grant got=%b exp=1", req1_ready); end
        checks++;
        if (rsp_valid !== 1'b1 || {rsp_id, rsp_sum} !== q[0]) begin
            errors++; $display("FAIL ip_head got=%b/%b/%h exp=1/%h", rsp_valid, rsp_id, rsp_sum, q[0]);
        end
        void'(q.pop_front());
        q.push_back({1'b1, 17'h00505});
        step();
        idle_inputs();
        rsp_ready = 0;
        req0_valid = 1; req0_a = 16'h0700; req0_b = 16'h0007;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL ip_credit_left got=%b exp=1", req0_ready); end
        q.push_back({1'b0, 17'h00707});
        step();
        checks++;
        if (req0_ready !== 1'b0) begin errors++; $display("FAIL ip_credit_full got=%b exp=0", req0_ready); end
        idle_inputs();
        for (int c = 0; c < 4; c++) step();
        rsp_ready = 1;
        for (int c = 0; c < 12 && q.size() > 0; c++) begin
            if (rsp_valid) begin
                checks++;
                if ({rsp_id, rsp_sum} !== q[0]) begin
                    errors++; $display("FAIL ip_order got=%b/%h exp=%h", rsp_id, rsp_sum, q[0]);
                end
                void'(q.pop_front());
            end
            step();
        end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL ip_drain_timeout left=%0d exp=0", q.size()); end
        step();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ip_duplicate got=%b exp=0", rsp_valid); end
        rsp_ready = 0;
    endtask

    task automatic test_mid_reset();
        int seen;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1; req0_a = 16'h0100; req0_b = 16'(i);
            step();
        end
        idle_inputs();
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mr_pre got=%b exp=1", rsp_valid); end
        rst = 1;
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL mr_ready got=%b%b exp=00", req0_ready, req1_ready);
        end
        step();
        rst = 0;
        idle_inputs();
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL mr_stale got=%0d exp=0", seen); end
        req0_valid = 1; req0_a = 16'h4000; req0_b = 16'h0001;
        req1_valid = 1; req1_a = 16'h8000; req1_b = 16'h0002;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL mr_first_grant got=%b%b exp=10", req0_ready, req1_ready);
        end
        step();
        idle_inputs();
        step();
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_sum !== 17'h04001) begin
            errors++; $display("FAIL mr_result got=%b/%b/%h exp=1/0/04001", rsp_valid, rsp_id, rsp_sum);
        end
        rsp_ready = 1;
        step();
        rsp_ready = 0;
    endtask

    initial begin
        rst = 1;
        rsp_ready = 0;
        idle_inputs();
        test_reset();
        test_single_issue();
        test_carry_out();
        test_contention();
        test_backpressure();
        test_issue_and_pop();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end
endmodule
